// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with HI/LO result registers.
// Latency: done is raised at the (WIDTH+1)th edge after start is accepted (1st edge for divide-by-zero).
// Backpressure: start is ignored while busy=1 and in the cycle done=1, so requests are never queued.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, op, a_in, b_in request; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   busy, done, div_zero  status; done and div_zero are single-cycle pulses
//   hi_out, lo_out        MULT: product upper/lower half; DIV: remainder/quotient
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W2-1:0]     acc_q, acc_d;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]  mb_q, mb_d;        // magnitude of b (multiplicand added / divisor)
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;      // product/quotient must be negated
  logic              rneg_q, rneg_d;    // remainder takes the dividend's sign
  logic              dz_q, dz_d;
  logic              done_q, done_d;
  logic              div_zero_q, div_zero_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  // Operand conditioning at acceptance; unsigned ops never flag a sign.
  logic             a_neg, b_neg, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg  = ~op[0] & a_in[WIDTH-1];
  assign b_neg  = ~op[0] & b_in[WIDTH-1];
  assign a_mag  = a_neg ? -a_in : a_in;
  assign b_mag  = b_neg ? -b_in : b_in;
  // A request in the done cycle is dropped; it is taken at the following edge.
  assign accept = (state_q == S_IDLE) && start && !done_q;

  // Shift-add step: conditionally add into the upper half, then shift the whole accumulator right.
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? mb_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder, subtract if it fits.
  // The shifted remainder needs WIDTH+1 bits; after a successful subtract it is below the divisor again.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             div_ge;
  logic [W2-1:0]    div_next;
  assign rem_sh   = acc_q[W2-1:WIDTH-1];
  assign div_ge   = rem_sh >= {1'b0, mb_q};
  assign rem_sub  = rem_sh[WIDTH-1:0] - mb_q;
  assign div_next = div_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Sign fix-up of the magnitude results.
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;
  assign prod = neg_q  ? -acc_q : acc_q;
  assign quo  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mb_d       = mb_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          mb_d     = b_mag;
          acc_d    = {{WIDTH{1'b0}}, a_mag};
          cnt_d    = '0;
          if (op[1] && (b_in == '0)) begin
            dz_d    = 1'b1;
            state_d = S_FIN;
          end else begin
            dz_d    = 1'b0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        done_d     = 1'b1;
        div_zero_d = dz_q;
        if (!dz_q) begin
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mb_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mb_q       <= mb_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 and WIDTH=8 (two instances, shared clock and reset).
// Latency is counted in clock edges after the accepting edge; outputs are sampled on the falling edge.
// A done seen after k edges means done was raised by edge E0+k and is sampled at edge E0+k+1.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, start8;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int errors = 0;
  int checks = 0;
  bit sel8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .a_in(a), .b_in(b),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi_out(hi32), .lo_out(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .a_in(a[7:0]), .b_in(b[7:0]),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi_out(hi8), .lo_out(lo8)
  );

  // View of the instance under test.
  logic        busy_s, done_s, dz_s;
  logic [31:0] hi_s, lo_s;
  assign busy_s = sel8 ? busy8 : busy32;
  assign done_s = sel8 ? done8 : done32;
  assign dz_s   = sel8 ? dz8   : dz32;
  assign hi_s   = sel8 ? {24'h0, hi8} : hi32;
  assign lo_s   = sel8 ? {24'h0, lo8} : lo32;

  function automatic int wd();
    return sel8 ? 8 : 32;
  endfunction

  task automatic set_start(input logic v);
    if (sel8) start8 = v; else start32 = v;
  endtask

  // Issue one operation from idle, scramble the operand inputs after acceptance, and wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int bc, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output logic pulse_after);
    @(negedge clk);
    op = o; a = av; b = bv; set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0); a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    lat = 0; bc = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_s) break;
      if (busy_s) bc++;
      @(negedge clk);
      lat++;
    end
    hi = hi_s; lo = lo_s; dz = dz_s;
    @(negedge clk);
    pulse_after = done_s | dz_s;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy32, done32, dz32} !== 3'b000) begin errors++; $display("FAIL reset_flags32 got=%b exp=000", {busy32, done32, dz32}); end
    checks++; if ({hi32, lo32} !== 64'h0) begin errors++; $display("FAIL reset_hilo32 got=%h exp=0", {hi32, lo32}); end
    checks++; if ({busy8, done8, dz8} !== 3'b000) begin errors++; $display("FAIL reset_flags8 got=%b exp=000", {busy8, done8, dz8}); end
    checks++; if ({hi8, lo8} !== 16'h0) begin errors++; $display("FAIL reset_hilo8 got=%h exp=0", {hi8, lo8}); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int lat, bc; logic [31:0] hi, lo; logic dz, pa;
    // -3 * 7 = -21
    run_op(2'b00, sel8 ? 32'hFD : 32'hFFFF_FFFD, 32'd7, lat, bc, hi, lo, dz, pa);
    checks++; if (lat !== wd() + 1) begin errors++; $display("FAIL mult_latency w=%0d got=%0d exp=%0d", wd(), lat, wd() + 1); end
    checks++; if (bc !== wd() + 1) begin errors++; $display("FAIL mult_busy_cycles w=%0d got=%0d exp=%0d", wd(), bc, wd() + 1); end
    checks++; if (hi !== (sel8 ? 32'hFF : 32'hFFFF_FFFF)) begin errors++; $display("FAIL mult_neg_hi w=%0d got=%h", wd(), hi); end
    checks++; if (lo !== (sel8 ? 32'hEB : 32'hFFFF_FFEB)) begin errors++; $display("FAIL mult_neg_lo w=%0d got=%h", wd(), lo); end
    checks++; if ({dz, pa} !== 2'b00) begin errors++; $display("FAIL mult_pulses w=%0d got dz=%b after=%b exp 0 0", wd(), dz, pa); end
    // MULTU all-ones squared
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, hi, lo, dz, pa);
    checks++; if (hi !== (sel8 ? 32'hFE : 32'hFFFF_FFFE)) begin errors++; $display("FAIL multu_hi w=%0d got=%h", wd(), hi); end
    checks++; if (lo !== 32'h1) begin errors++; $display("FAIL multu_lo w=%0d got=%h exp=1", wd(), lo); end
    // MIN * MIN is exact: 2^(2W-2)
    run_op(2'b00, sel8 ? 32'h80 : 32'h8000_0000, sel8 ? 32'h80 : 32'h8000_0000, lat, bc, hi, lo, dz, pa);
    checks++; if ({hi, lo} !== (sel8 ? 64'h40_0000_0000 : 64'h4000_0000_0000_0000)) begin errors++; $display("FAIL mult_min_min w=%0d got=%h_%h", wd(), hi, lo); end
    // 0x12(345678) * 0x10
    run_op(2'b00, sel8 ? 32'h12 : 32'h1234_5678, 32'h10, lat, bc, hi, lo, dz, pa);
    checks++; if ({hi, lo} !== (sel8 ? 64'h1_0000_0020 : 64'h1_2345_6780)) begin errors++; $display("FAIL mult_pos w=%0d got=%h_%h", wd(), hi, lo); end
  endtask

  task automatic test_div();
    int lat, bc; logic [31:0] hi, lo; logic dz, pa;
    // -7 / 2 = -3 rem -1
    run_op(2'b10, sel8 ? 32'hF9 : 32'hFFFF_FFF9, 32'd2, lat, bc, hi, lo, dz, pa);
    checks++; if (lat !== wd() + 1) begin errors++; $display("FAIL div_latency w=%0d got=%0d exp=%0d", wd(), lat, wd() + 1); end
    checks++; if (lo !== (sel8 ? 32'hFD : 32'hFFFF_FFFD)) begin errors++; $display("FAIL div_neg_quot w=%0d got=%h", wd(), lo); end
    checks++; if (hi !== (sel8 ? 32'hFF : 32'hFFFF_FFFF)) begin errors++; $display("FAIL div_neg_rem w=%0d got=%h", wd(), hi); end
    // DIVU 7 / 2 = 3 rem 1
    run_op(2'b11, 32'd7, 32'd2, lat, bc, hi, lo, dz, pa);
    checks++; if ({hi, lo} !== {32'd1, 32'd3}) begin errors++; $display("FAIL divu_small w=%0d got hi=%h lo=%h exp 1 3", wd(), hi, lo); end
    // 7 / -2 = -3 rem 1 (remainder follows the dividend)
    run_op(2'b10, 32'd7, sel8 ? 32'hFE : 32'hFFFF_FFFE, lat, bc, hi, lo, dz, pa);
    checks++; if ({hi, lo} !== {32'd1, (sel8 ? 32'hFD : 32'hFFFF_FFFD)}) begin errors++; $display("FAIL div_negdivisor w=%0d got hi=%h lo=%h", wd(), hi, lo); end
    // MIN / -1 wraps to MIN, no flag
    run_op(2'b10, sel8 ? 32'h80 : 32'h8000_0000, sel8 ? 32'hFF : 32'hFFFF_FFFF, lat, bc, hi, lo, dz, pa);
    checks++; if ({hi, lo} !== {32'd0, (sel8 ? 32'h80 : 32'h8000_0000)}) begin errors++; $display("FAIL div_overflow w=%0d got hi=%h lo=%h", wd(), hi, lo); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_overflow_flag w=%0d got=%b exp=0", wd(), dz); end
    // DIVU all-ones / 1
    run_op(2'b11, 32'hFFFF_FFFF, 32'd1, lat, bc, hi, lo, dz, pa);
    checks++; if ({hi, lo} !== {32'd0, (sel8 ? 32'hFF : 32'hFFFF_FFFF)}) begin errors++; $display("FAIL divu_max w=%0d got hi=%h lo=%h", wd(), hi, lo); end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [31:0] hi, lo; logic dz, pa;
    // 95 / 10 leaves hi=5, lo=9
    run_op(2'b11, 32'd95, 32'd10, lat, bc, hi, lo, dz, pa);
    checks++; if ({hi, lo} !== {32'd5, 32'd9}) begin errors++; $display("FAIL dz_setup w=%0d got hi=%h lo=%h exp 5 9", wd(), hi, lo); end
    run_op(2'b10, 32'd123, 32'd0, lat, bc, hi, lo, dz, pa);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency w=%0d got=%0d exp=1", wd(), lat); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL dz_busy_cycles w=%0d got=%0d exp=1", wd(), bc); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag w=%0d got=%b exp=1", wd(), dz); end
    checks++; if ({hi, lo} !== {32'd5, 32'd9}) begin errors++; $display("FAIL dz_hold w=%0d got hi=%h lo=%h exp 5 9", wd(), hi, lo); end
    checks++; if (pa !== 1'b0) begin errors++; $display("FAIL dz_pulse_width w=%0d got=%b exp=0", wd(), pa); end
    run_op(2'b11, 32'd9, 32'd0, lat, bc, hi, lo, dz, pa);
    checks++; if ({dz, hi, lo} !== {1'b1, 32'd5, 32'd9}) begin errors++; $display("FAIL divu_zero w=%0d got dz=%b hi=%h lo=%h", wd(), dz, hi, lo); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd4; set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    a = 32'd5; b = 32'd6;  // start stays high throughout
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_s) break;
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== wd() + 1) begin errors++; $display("FAIL b2b_latency w=%0d got=%0d exp=%0d", wd(), lat, wd() + 1); end
    checks++; if ({hi_s, lo_s} !== {32'd0, 32'd12}) begin errors++; $display("FAIL b2b_first w=%0d got hi=%h lo=%h exp 0 12", wd(), hi_s, lo_s); end
    @(negedge clk);
    checks++; if ({busy_s, done_s} !== 2'b00) begin errors++; $display("FAIL b2b_done_cycle_ignored w=%0d got busy=%b done=%b exp 0 0", wd(), busy_s, done_s); end
    @(negedge clk);
    checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL b2b_accept_after_done w=%0d got busy=%b exp=1", wd(), busy_s); end
    set_start(1'b0);
    for (int i = 0; i < 100; i++) begin
      if (done_s) break;
      @(negedge clk);
    end
    checks++; if ({done_s, hi_s, lo_s} !== {1'b1, 32'd0, 32'd30}) begin errors++; $display("FAIL b2b_second w=%0d got done=%b hi=%h lo=%h exp 1 0 30", wd(), done_s, hi_s, lo_s); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd7; set_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({busy_s, done_s, dz_s} !== 3'b000) begin errors++; $display("FAIL midreset_flags w=%0d got=%b exp=000", wd(), {busy_s, done_s, dz_s}); end
    checks++; if ({hi_s, lo_s} !== 64'h0) begin errors++; $display("FAIL midreset_hilo w=%0d got hi=%h lo=%h exp 0 0", wd(), hi_s, lo_s); end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < wd() + 6; i++) begin
      @(negedge clk);
      if (done_s || busy_s) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done w=%0d got activity=%b exp=0", wd(), seen); end
  endtask

  initial begin
    reset = 1'b1; start32 = 1'b0; start8 = 1'b0; op = 2'b00; a = '0; b = '0; sel8 = 1'b0;
    test_reset();
    for (int s = 0; s < 2; s++) begin
      sel8 = s[0];
      test_mult();
      test_div();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
